// File: rtl/dsp_avg_pkg.sv
// Shared definitions for the dsp_avg frame averager: width defaults,
// FSM state encoding and the phase wrap helper.
package dsp_avg_pkg;

  localparam int MW_DEF   = 20;
  localparam int PW_DEF   = 21;
  localparam int MAXL_DEF = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Reduce a wide phase value modulo 2^PW (full scale = 2*pi).
  function automatic logic [PW_DEF-1:0] wrap_PW(input logic [PW_DEF+MAXL_DEF-1:0] x);
    return PW_DEF'(x);
  endfunction

endpackage

// File: rtl/dsp_avg_if.sv
// Readout-side bundle of dsp_avg: averaged magnitudes/phases, the
// valid/ready handshake and the overrun counter.
interface dsp_avg_if
  import dsp_avg_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int PW = PW_DEF
);
  logic [MW-1:0] avg_mag_ref;
  logic [MW-1:0] avg_mag_a;
  logic [MW-1:0] avg_mag_b;
  logic [MW-1:0] avg_mag_c;
  logic [PW-1:0] avg_phase_ref;
  logic [PW-1:0] avg_phase_a;
  logic [PW-1:0] avg_phase_b;
  logic [PW-1:0] avg_phase_c;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   overrun_cnt;

  modport master (
    output avg_mag_ref, avg_mag_a, avg_mag_b, avg_mag_c,
    output avg_phase_ref, avg_phase_a, avg_phase_b, avg_phase_c,
    output out_valid, overrun_cnt,
    input  out_ready
  );

  modport slave (
    input  avg_mag_ref, avg_mag_a, avg_mag_b, avg_mag_c,
    input  avg_phase_ref, avg_phase_a, avg_phase_b, avg_phase_c,
    input  out_valid, overrun_cnt,
    output out_ready
  );

endinterface

// File: rtl/dsp_avg_chan.sv
// One magnitude+phase accumulator pair. Phase is accumulated as the
// wrapped difference from the first frame (p0) of the window, so the
// average is immune to the +/-pi seam.
module dsp_avg_chan
  import dsp_avg_pkg::*;
#(
  parameter int MW   = MW_DEF,
  parameter int PW   = PW_DEF,
  parameter int MAXL = MAXL_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          add,
  input  logic [3:0]    shift,
  input  logic [MW-1:0] mag_in,
  input  logic [PW-1:0] phase_in,
  output logic [MW-1:0] mag_res,
  output logic [PW-1:0] phase_res
);

  localparam int MAW = MW + MAXL;
  localparam int PAW = PW + MAXL;

  logic [MAW-1:0]        acc_mag;
  logic signed [PAW-1:0] acc_ph;
  logic [PW-1:0]         p0;
  logic [PW-1:0]         diff;
  logic signed [PAW-1:0] ph_sh;

  assign diff = phase_in - p0;

  // First frame seeds magnitude and p0; later frames accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_mag <= '0;
      acc_ph  <= '0;
      p0      <= '0;
    end else if (load) begin
      acc_mag <= {{MAXL{1'b0}}, mag_in};
      acc_ph  <= '0;
      p0      <= phase_in;
    end else if (add) begin
      acc_mag <= acc_mag + {{MAXL{1'b0}}, mag_in};
      acc_ph  <= acc_ph + {{MAXL{diff[PW-1]}}, diff};
    end
  end

  assign mag_res   = MW'(acc_mag >> shift);
  assign ph_sh     = acc_ph >>> shift;
  assign phase_res = wrap_PW(PAW'(ph_sh + {{MAXL{1'b0}}, p0}));

endmodule

// File: rtl/dsp_avg.sv
// Frame averager: accumulates 2^avg_log2 frames of ref/a/b/c magnitude
// and phase, presents the average over a valid/ready handshake and
// drops results that arrive while the previous one is still held.
// Optional: define DSP_AVG_OVERRUN_CNT_EN to build the overrun counter.
module dsp_avg
  import dsp_avg_pkg::*;
#(
  parameter int MW   = MW_DEF,
  parameter int PW   = PW_DEF,
  parameter int MAXL = MAXL_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_strobe,
  input  logic [MW-1:0] mag_ref,
  input  logic [MW-1:0] mag_a,
  input  logic [MW-1:0] mag_b,
  input  logic [MW-1:0] mag_c,
  input  logic [PW-1:0] phase_ref,
  input  logic [PW-1:0] phase_a,
  input  logic [PW-1:0] phase_b,
  input  logic [PW-1:0] phase_c,
  input  logic [3:0]    avg_log2,
  dsp_avg_if.master     bus
);

  state_t                state;
  logic [3:0]            l_cur;
  logic [3:0]            l_new;
  logic [MAXL-1:0]       cnt;
  logic                  done_q;
  logic                  load;
  logic                  add;
  logic [3:0][MW-1:0]    mag_in_v;
  logic [3:0][PW-1:0]    ph_in_v;
  logic [3:0][MW-1:0]    mag_res_v;
  logic [3:0][PW-1:0]    ph_res_v;
  logic [3:0][MW-1:0]    mag_q;
  logic [3:0][PW-1:0]    ph_q;
  logic                  valid_q;
  logic                  accept;

  assign l_new    = (avg_log2 > 4'(MAXL)) ? 4'(MAXL) : avg_log2;
  assign load     = in_strobe && (state == IDLE);
  assign add      = in_strobe && (state == ACCUM);
  assign mag_in_v = {mag_c, mag_b, mag_a, mag_ref};
  assign ph_in_v  = {phase_c, phase_b, phase_a, phase_ref};

  for (genvar c = 0; c < 4; c++) begin : g_chan
    dsp_avg_chan #(.MW(MW), .PW(PW), .MAXL(MAXL)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .add       (add),
      .shift     (l_cur),
      .mag_in    (mag_in_v[c]),
      .phase_in  (ph_in_v[c]),
      .mag_res   (mag_res_v[c]),
      .phase_res (ph_res_v[c])
    );
  end

  // Window sequencing: latch L at window start, count frames, flag completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      l_cur  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_strobe) begin
            l_cur <= l_new;
            cnt   <= MAXL'((32'd1 << l_new) - 32'd1);
            if (l_new == 4'd0) begin
              done_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_strobe) begin
            cnt <= cnt - 1'b1;
            if (cnt == MAXL'(1)) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completed window is taken only if the output slot is free or being emptied now.
  assign accept = done_q && (!valid_q || bus.out_ready);

  // Output slot: a same-cycle load wins over the consumer's clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      mag_q   <= '0;
      ph_q    <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      mag_q   <= mag_res_v;
      ph_q    <= ph_res_v;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DSP_AVG_OVERRUN_CNT_EN
  logic [15:0] ovr_q;

  // Count dropped windows, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q <= '0;
    end else if (done_q && !accept && (ovr_q != '1)) begin
      ovr_q <= ovr_q + 16'd1;
    end
  end

  assign bus.overrun_cnt = ovr_q;
`else
  assign bus.overrun_cnt = '0;
`endif

  assign bus.avg_mag_ref   = mag_q[0];
  assign bus.avg_mag_a     = mag_q[1];
  assign bus.avg_mag_b     = mag_q[2];
  assign bus.avg_mag_c     = mag_q[3];
  assign bus.avg_phase_ref = ph_q[0];
  assign bus.avg_phase_a   = ph_q[1];
  assign bus.avg_phase_b   = ph_q[2];
  assign bus.avg_phase_c   = ph_q[3];
  assign bus.out_valid     = valid_q;

endmodule

// File: tb/tb_dsp_avg.sv
// Scoreboard bench for dsp_avg: stimulus pushes expected averages computed
// from the raw frames; a negedge monitor compares whatever the DUT presents.
module tb_dsp_avg;

  typedef struct packed {
    logic [3:0][20:0] ph;
    logic [3:0][19:0] mag;
  } bundle_t;

  localparam longint FS = longint'(1) << 21;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_strobe = 1'b0;
  logic [19:0] mag_ref = '0, mag_a = '0, mag_b = '0, mag_c = '0;
  logic [20:0] phase_ref = '0, phase_a = '0, phase_b = '0, phase_c = '0;
  logic [3:0]  avg_log2 = '0;

  dsp_avg_if bus ();

  dsp_avg dut (
    .clk       (clk),
    .reset     (reset),
    .in_strobe (in_strobe),
    .mag_ref   (mag_ref),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .mag_c     (mag_c),
    .phase_ref (phase_ref),
    .phase_a   (phase_a),
    .phase_b   (phase_b),
    .phase_c   (phase_c),
    .avg_log2  (avg_log2),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      fails = 0;
  bundle_t exp_q[$];
  bundle_t win_q[$];
  int      lm = 0;
  int      drops_pending = 0;
  int      exp_ovr = 0;

  function automatic int ovr_expected();
`ifdef DSP_AVG_OVERRUN_CNT_EN
    return exp_ovr;
`else
    return 0;
`endif
  endfunction

  function automatic bundle_t act_bundle();
    bundle_t b;
    b.mag = {bus.avg_mag_c, bus.avg_mag_b, bus.avg_mag_a, bus.avg_mag_ref};
    b.ph  = {bus.avg_phase_c, bus.avg_phase_b, bus.avg_phase_a, bus.avg_phase_ref};
    return b;
  endfunction

  // Reference: plain mean of magnitudes; phase = p0 + floor(mean of wrapped offsets).
  function automatic bundle_t model_avg();
    bundle_t r;
    longint  den;
    den = longint'(1) << lm;
    for (int c = 0; c < 4; c++) begin
      longint ms, ds, p0, d, q;
      ms = 0;
      ds = 0;
      p0 = longint'(win_q[0].ph[c]);
      foreach (win_q[i]) begin
        ms += longint'(win_q[i].mag[c]);
        d = longint'(win_q[i].ph[c]) - p0;
        if (d >= 64'sd1048576) d -= FS;
        else if (d < -64'sd1048576) d += FS;
        ds += d;
      end
      r.mag[c] = 20'(ms / den);
      q = ds / den;
      if (ds < 0 && q * den != ds) q -= 1;
      r.ph[c] = 21'((((p0 + q) % FS) + FS) % FS);
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after a posedge, gap cycles later.
  task automatic send_frame(input bundle_t f, input int gap, input bit raise_ready);
    if (win_q.size() == 0) lm = (avg_log2 > 4'd8) ? 8 : int'(avg_log2);
    mag_ref = f.mag[0]; mag_a = f.mag[1]; mag_b = f.mag[2]; mag_c = f.mag[3];
    phase_ref = f.ph[0]; phase_a = f.ph[1]; phase_b = f.ph[2]; phase_c = f.ph[3];
    in_strobe = 1'b1;
    win_q.push_back(f);
    if (win_q.size() == (1 << lm)) begin
      bundle_t e;
      e = model_avg();
      win_q.delete();
      if (drops_pending > 0) begin
        drops_pending--;
        if (exp_ovr < 65535) exp_ovr++;
      end else begin
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_strobe = 1'b0;
    if (raise_ready) bus.out_ready = 1'b1;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  function automatic bundle_t rand_frame();
    bundle_t f;
    for (int c = 0; c < 4; c++) begin
      f.mag[c] = 20'($urandom);
      f.ph[c]  = 21'($urandom);
    end
    return f;
  endfunction

  function automatic bundle_t const_frame(input logic [19:0] m, input logic [20:0] pa);
    bundle_t f;
    f.mag = {m, m, m, m};
    f.ph  = {21'd0, 21'd0, pa, 21'd0};
    return f;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d results still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    bundle_t z;
    z = '0;
    chk({name, "_valid"}, longint'(bus.out_valid), 0);
    chk({name, "_ovr"}, longint'(bus.overrun_cnt), 0);
    checks++;
    if (act_bundle() != z) begin
      fails++;
      $display("FAIL %s_bundle: got %h, expected 0", name, act_bundle());
    end
  endtask

  // Monitor: every cycle a bundle is presented it must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got bundle %h, expected no output", act_bundle());
      end else begin
        if (act_bundle() != exp_q[0]) begin
          fails++;
          $display("FAIL bundle: got %h, expected %h", act_bundle(), exp_q[0]);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // L=2: mean of 100..400 is 250, constant phase stays 1000.
    avg_log2 = 4'd2;
    for (int i = 1; i <= 4; i++) send_frame(const_frame(20'(100 * i), 21'd1000), 3, 1'b0);
    drain("basic");

    // Phase averaging across the +/-pi seam, L=1.
    avg_log2 = 4'd1;
    send_frame(const_frame(20'd5, 21'h0FFFF0), 3, 1'b0);
    send_frame(const_frame(20'd7, 21'h100010), 3, 1'b0);
    send_frame(const_frame(20'd9, 21'h100010), 4, 1'b0);
    send_frame(const_frame(20'd1, 21'h0FFFF0), 4, 1'b0);
    send_frame(const_frame(20'd3, 21'h1FFFF0), 3, 1'b0);
    send_frame(const_frame(20'd4, 21'h000010), 3, 1'b0);
    drain("wrap");

    // Randomized windows, consumer always ready.
    for (int w = 0; w < 20; w++) begin
      int nfr;
      avg_log2 = 4'($urandom_range(0, 4));
      nfr = 1 << int'(avg_log2);
      for (int i = 0; i < nfr; i++) send_frame(rand_frame(), $urandom_range(3, 6), 1'b0);
    end
    drain("random");

    // avg_log2 changed mid-window: the window keeps its 4-frame length.
    avg_log2 = 4'd2;
    send_frame(rand_frame(), 3, 1'b0);
    avg_log2 = 4'd0;
    for (int i = 0; i < 3; i++) send_frame(rand_frame(), 3, 1'b0);
    drain("midchange");

    // Oversized avg_log2 clamps to 256 frames.
    avg_log2 = 4'd15;
    for (int i = 0; i < 256; i++) send_frame(rand_frame(), 3, 1'b0);
    drain("clamp");

    // Held output: two later windows are dropped, first result stays stable.
    avg_log2 = 4'd0;
    bus.out_ready = 1'b0;
    send_frame(rand_frame(), 3, 1'b0);
    drops_pending = 2;
    send_frame(rand_frame(), 3, 1'b0);
    send_frame(rand_frame(), 3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("overrun_after_drops", longint'(bus.overrun_cnt), longint'(ovr_expected()));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_after_accept", longint'(bus.out_valid), 0);
    drain("overrun");

    // Completion while the consumer accepts the previous result: new one loads.
    send_frame(rand_frame(), 3, 1'b0);
    send_frame(rand_frame(), 3, 1'b1);
    drain("simultaneous");
    chk("overrun_unchanged", longint'(bus.overrun_cnt), longint'(ovr_expected()));

    // Reset with a held result and a half-filled window.
    bus.out_ready = 1'b0;
    avg_log2 = 4'd0;
    send_frame(rand_frame(), 3, 1'b0);
    avg_log2 = 4'd2;
    send_frame(rand_frame(), 3, 1'b0);
    send_frame(rand_frame(), 3, 1'b0);
    reset = 1'b1;
    #1;
    exp_q.delete();
    win_q.delete();
    exp_ovr = 0;
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_frame(rand_frame(), 3, 1'b0);
    drain("post_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
